// File: rtl/sram_access_ctrl_pkg.sv
// Shared constants for the external 16-bit SRAM access controller:
// state encoding, default geometry/timing and op-select values.
package sram_access_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W      = 18;
  localparam int unsigned SRAM_WAIT_CYCLES = 2;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned HALF_W           = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Counter reload value for a phase of wc cycles
  function automatic logic [CNT_W-1:0] phase_load(input int unsigned wc);
    return CNT_W'(wc - 1);
  endfunction

endpackage

// File: rtl/sram_access_ctrl_phase_timer.sv
// Loadable down-counter timing one halfword phase.
// o_phase_last_c : current cycle is the last of the phase.
// o_we_window_c  : the next cycle lies inside the write-enable window.
module sram_phase_timer
  import sram_access_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = SRAM_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_phase_last_c,
  output logic o_we_window_c
);

  localparam logic [CNT_W-1:0] LOAD_VAL = phase_load(WAIT_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Reload at phase entry, otherwise count down and park at zero
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = LOAD_VAL;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_phase_last_c = (r_cnt == '0);
  // we_n drops while the counter is non-zero; a one-cycle phase keeps it low throughout
  assign o_we_window_c  = (w_cnt_nxt != '0) || (WAIT_CYCLES == 32'd1);

endmodule

// File: rtl/sram_access_ctrl.sv
// Sequences 32-bit MEM-stage loads/stores as two halfword accesses to an
// asynchronous 16-bit SRAM, stalling the pipeline via freeze_out.
// Optional macro SRAM_ACCESS_BYPASS_EN: loads hitting the last completed
// store are served from a local register without an SRAM cycle.
module sram_access_ctrl
  import sram_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = SRAM_ADDR_W,
  parameter int unsigned WAIT_CYCLES = SRAM_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wdata_in,
  output logic [31:0]       rdata_out,
  output logic              ready_out,
  output logic              freeze_out,
  output logic [ADDR_W-1:0] sram_addr_out,
  output logic [15:0]       sram_wdata_out,
  input  logic [15:0]       sram_rdata_in,
  output logic              sram_we_n_out,
  output logic              sram_oe_n_out
);

  localparam int unsigned WORD_W = ADDR_W - 1;

  logic [1:0]          r_state, w_state_nxt;
  logic                r_op, w_op_nxt;
  logic [WORD_W-1:0]   r_word, w_word_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [HALF_W-1:0]   r_rdata_lo, w_rdata_lo_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_ready, w_ready_nxt;
  logic [ADDR_W-1:0]   r_sram_addr, w_sram_addr_nxt;
  logic [HALF_W-1:0]   r_sram_wdata, w_sram_wdata_nxt;
  logic                r_we_n, w_we_n_nxt;
  logic                r_oe_n, w_oe_n_nxt;

  logic [WORD_W-1:0]   w_word_in;
  logic                w_req, w_op_in, w_start, w_load;
  logic                w_phase_last, w_we_window;
  logic                w_bypass_hit;
  logic [DATA_W-1:0]   w_byp_data;
  logic                w_unused;

  assign w_word_in = addr_in[ADDR_W:2];
  assign w_req     = mem_read_in | mem_write_in;
  assign w_op_in   = mem_write_in ? OP_WRITE : OP_READ;
  assign w_unused  = ^{addr_in[31:ADDR_W+1], addr_in[1:0]};

`ifdef SRAM_ACCESS_BYPASS_EN
  logic                r_byp_valid;
  logic [WORD_W-1:0]   r_byp_word;
  logic [DATA_W-1:0]   r_byp_data;

  // Remember the most recently completed store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp_valid <= 1'b0;
      r_byp_word  <= '0;
      r_byp_data  <= '0;
    end else if ((r_state == ST_HIGH) && w_phase_last && (r_op == OP_WRITE)) begin
      r_byp_valid <= 1'b1;
      r_byp_word  <= r_word;
      r_byp_data  <= r_wdata;
    end
  end

  assign w_bypass_hit = r_byp_valid && !mem_write_in && (r_byp_word == w_word_in);
  assign w_byp_data   = r_byp_data;
`else
  assign w_bypass_hit = 1'b0;
  assign w_byp_data   = '0;
`endif

  assign w_start    = (r_state == ST_IDLE) && w_req && !w_bypass_hit;
  assign w_load     = w_start || ((r_state == ST_LOW) && w_phase_last);
  // DONE releases the stall in the same cycle as the ready pulse
  assign freeze_out = w_req && (r_state != ST_DONE);

  sram_phase_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phase_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_load         (w_load),
    .o_phase_last_c (w_phase_last),
    .o_we_window_c  (w_we_window)
  );

  // Next state plus next values for every registered output
  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_word_nxt       = r_word;
    w_wdata_nxt      = r_wdata;
    w_rdata_lo_nxt   = r_rdata_lo;
    w_rdata_nxt      = r_rdata;
    w_ready_nxt      = 1'b0;
    w_sram_addr_nxt  = r_sram_addr;
    w_sram_wdata_nxt = r_sram_wdata;
    w_we_n_nxt       = 1'b1;
    w_oe_n_nxt       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_op_nxt    = w_op_in;
          w_word_nxt  = w_word_in;
          w_wdata_nxt = wdata_in;
          if (w_bypass_hit) begin
            w_state_nxt = ST_DONE;
            w_ready_nxt = 1'b1;
            w_rdata_nxt = w_byp_data;
          end else begin
            w_state_nxt      = ST_LOW;
            w_sram_addr_nxt  = {w_word_in, 1'b0};
            w_sram_wdata_nxt = wdata_in[15:0];
            w_we_n_nxt       = !((w_op_in == OP_WRITE) && w_we_window);
            w_oe_n_nxt       = (w_op_in != OP_READ);
          end
        end
      end
      ST_LOW: begin
        w_we_n_nxt = !((r_op == OP_WRITE) && w_we_window);
        w_oe_n_nxt = (r_op != OP_READ);
        if (w_phase_last) begin
          w_state_nxt      = ST_HIGH;
          w_sram_addr_nxt  = {r_word, 1'b1};
          w_sram_wdata_nxt = r_wdata[31:16];
          w_rdata_lo_nxt   = sram_rdata_in;
        end
      end
      ST_HIGH: begin
        if (w_phase_last) begin
          w_state_nxt = ST_DONE;
          w_ready_nxt = 1'b1;
          if (r_op == OP_READ) begin
            w_rdata_nxt = {sram_rdata_in, r_rdata_lo};
          end
        end else begin
          w_we_n_nxt = !((r_op == OP_WRITE) && w_we_window);
          w_oe_n_nxt = (r_op != OP_READ);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand latches and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= OP_READ;
      r_word       <= '0;
      r_wdata      <= '0;
      r_rdata_lo   <= '0;
      r_rdata      <= '0;
      r_ready      <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_we_n       <= 1'b1;
      r_oe_n       <= 1'b1;
    end else begin
      r_op         <= w_op_nxt;
      r_word       <= w_word_nxt;
      r_wdata      <= w_wdata_nxt;
      r_rdata_lo   <= w_rdata_lo_nxt;
      r_rdata      <= w_rdata_nxt;
      r_ready      <= w_ready_nxt;
      r_sram_addr  <= w_sram_addr_nxt;
      r_sram_wdata <= w_sram_wdata_nxt;
      r_we_n       <= w_we_n_nxt;
      r_oe_n       <= w_oe_n_nxt;
    end
  end

  assign rdata_out      = r_rdata;
  assign ready_out      = r_ready;
  assign sram_addr_out  = r_sram_addr;
  assign sram_wdata_out = r_sram_wdata;
  assign sram_we_n_out  = r_we_n;
  assign sram_oe_n_out  = r_oe_n;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl with a behavioural 16-bit SRAM.
// Honours SRAM_ACCESS_BYPASS_EN when defined for the build.
module tb_sram_access_ctrl;
  import sram_access_ctrl_pkg::*;

  localparam int unsigned AW = SRAM_ADDR_W;
`ifdef SRAM_ACCESS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          mem_read_in;
  logic          mem_write_in;
  logic [31:0]   addr_in;
  logic [31:0]   wdata_in;
  logic [31:0]   rdata_out;
  logic          ready_out;
  logic          freeze_out;
  logic [AW-1:0] sram_addr_out;
  logic [15:0]   sram_wdata_out;
  logic [15:0]   sram_rdata_in;
  logic          sram_we_n_out;
  logic          sram_oe_n_out;

  sram_access_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .addr_in        (addr_in),
    .wdata_in       (wdata_in),
    .rdata_out      (rdata_out),
    .ready_out      (ready_out),
    .freeze_out     (freeze_out),
    .sram_addr_out  (sram_addr_out),
    .sram_wdata_out (sram_wdata_out),
    .sram_rdata_in  (sram_rdata_in),
    .sram_we_n_out  (sram_we_n_out),
    .sram_oe_n_out  (sram_oe_n_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: writes while we_n is low, reads while oe_n is low
  bit [15:0] sram_mem [0:(1<<AW)-1];
  always @(negedge clk) begin
    if (rst_n && !sram_we_n_out) sram_mem[sram_addr_out] = sram_wdata_out;
  end
  assign sram_rdata_in = sram_oe_n_out ? 16'h0000 : sram_mem[sram_addr_out];

  typedef struct packed {
    logic        rd;
    logic [31:0] data;
  } sb_t;

  sb_t           exp_q[$];
  bit [31:0]     ref_mem[int];
  logic [31:0]   last_rd;
  logic [AW-1:0] we_addr_q[$];
  logic [15:0]   we_data_q[$];
  int n_vec, n_err;
  int n_cyc, n_frz, n_we, n_oe, n_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_cyc = 0; n_frz = 0; n_we = 0; n_oe = 0; n_rdy = 0;
    we_addr_q.delete();
    we_data_q.delete();
  endtask

  // Drive one request, push its expected result, collect activity until ready
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wd);
    sb_t e;
    bit  done;
    int  idx;
    idx = int'(addr[AW:2]);
    @(posedge clk); #1;
    mem_read_in = rd; mem_write_in = wr; addr_in = addr; wdata_in = wd;
    if (wr) begin
      ref_mem[idx] = wd;
      e.rd = 1'b0; e.data = last_rd;
    end else begin
      e.rd = 1'b1;
      e.data = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
      last_rd = e.data;
    end
    exp_q.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      n_cyc++;
      if (freeze_out) n_frz++;
      if (!sram_we_n_out) begin
        n_we++;
        we_addr_q.push_back(sram_addr_out);
        we_data_q.push_back(sram_wdata_out);
      end
      if (!sram_oe_n_out) n_oe++;
      if (ready_out) begin
        done = 1'b1;
        n_rdy++;
        check("freeze_in_done", 32'(freeze_out), 32'd0);
        e = exp_q.pop_front();
        if (e.rd) check("load_rdata", rdata_out, e.data);
        else      check("store_rdata_hold", rdata_out, e.data);
      end
    end
    if (!done) check("access_timeout", 32'd0, 32'd1);
  endtask

  // Release the request after DONE and confirm the bus stays idle
  task automatic drop_req();
    bit busy;
    @(posedge clk); #1;
    mem_read_in = 1'b0; mem_write_in = 1'b0; addr_in = '0; wdata_in = '0;
    busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (!sram_we_n_out || !sram_oe_n_out || ready_out || freeze_out) busy = 1'b1;
    end
    check("idle_quiet", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_ready;
    n_vec = 0; n_err = 0; last_rd = '0;
    rst_n = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    addr_in = '0; wdata_in = '0;
    clear_stats();
    #12;
    check("rst_rdata",  rdata_out, 32'h0);
    check("rst_ready",  32'(ready_out), 32'd0);
    check("rst_we_n",   32'(sram_we_n_out), 32'd1);
    check("rst_oe_n",   32'(sram_oe_n_out), 32'd1);
    check("rst_addr",   32'(sram_addr_out), 32'h0);
    check("rst_wdata",  32'(sram_wdata_out), 32'h0);
    check("rst_freeze", 32'(freeze_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Store: two halfword writes, 5 frozen cycles, ready on cycle 6
    clear_stats();
    run_access(1'b0, 1'b1, 32'h0000_0408, 32'hDEAD_BEEF);
    check("st_cycles", 32'(n_cyc), 32'd6);
    check("st_freeze", 32'(n_frz), 32'd5);
    check("st_we_cnt", 32'(n_we),  32'd2);
    check("st_oe_cnt", 32'(n_oe),  32'd0);
    check("st_ready",  32'(n_rdy), 32'd1);
    if (we_addr_q.size() == 2) begin
      check("st_addr_lo", 32'(we_addr_q[0]), 32'h204);
      check("st_addr_hi", 32'(we_addr_q[1]), 32'h205);
      check("st_data_lo", 32'(we_data_q[0]), 32'hBEEF);
      check("st_data_hi", 32'(we_data_q[1]), 32'hDEAD);
    end
    drop_req();

    // Load back the same word
    clear_stats();
    run_access(1'b1, 1'b0, 32'h0000_0408, 32'h0);
    check("ld_freeze", 32'(n_frz), BYP ? 32'd1 : 32'd5);
    check("ld_oe_cnt", 32'(n_oe),  BYP ? 32'd0 : 32'd4);
    check("ld_we_cnt", 32'(n_we),  32'd0);
    drop_req();

    // Read and write together: write wins
    clear_stats();
    run_access(1'b1, 1'b1, 32'h0000_0800, 32'h1234_5678);
    check("rw_we_cnt", 32'(n_we), 32'd2);
    check("rw_oe_cnt", 32'(n_oe), 32'd0);
    if (we_data_q.size() == 2) begin
      check("rw_data_lo", 32'(we_data_q[0]), 32'h5678);
      check("rw_data_hi", 32'(we_data_q[1]), 32'h1234);
    end
    drop_req();
    check("rdata_kept_after_store", rdata_out, last_rd);
    clear_stats();
    run_access(1'b1, 1'b0, 32'h0000_0800, 32'h0);
    check("rw_ld_oe_cnt", 32'(n_oe), BYP ? 32'd0 : 32'd4);
    drop_req();

    // Reset asserted during the HIGH phase of a store
    @(posedge clk); #1;
    mem_write_in = 1'b1; addr_in = 32'h0000_0C00; wdata_in = 32'hAAAA_5555;
    repeat (4) @(negedge clk);
    check("mid_high_addr", 32'(sram_addr_out), 32'h601);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we_n",  32'(sram_we_n_out), 32'd1);
    check("mid_rst_oe_n",  32'(sram_oe_n_out), 32'd1);
    check("mid_rst_addr",  32'(sram_addr_out), 32'h0);
    check("mid_rst_wdata", 32'(sram_wdata_out), 32'h0);
    check("mid_rst_ready", 32'(ready_out), 32'd0);
    check("mid_rst_rdata", rdata_out, 32'h0);
    mem_write_in = 1'b0; addr_in = '0; wdata_in = '0;
    last_rd = '0;
    saw_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ready_out) saw_ready = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ready_out) saw_ready = 1'b1;
    end
    check("mid_rst_no_ready", 32'(saw_ready), 32'd0);

    // Clean restart after reset; the last-store record is gone too
    clear_stats();
    run_access(1'b1, 1'b0, 32'h0000_0408, 32'h0);
    check("post_rst_freeze", 32'(n_frz), 32'd5);
    check("post_rst_oe_cnt", 32'(n_oe),  32'd4);
    drop_req();

    // Back-to-back load then store with the request held throughout
    clear_stats();
    run_access(1'b1, 1'b0, 32'h0000_0800, 32'h0);
    run_access(1'b0, 1'b1, 32'h0000_040C, 32'h0BAD_F00D);
    check("b2b_cycles", 32'(n_cyc), 32'd12);
    check("b2b_ready",  32'(n_rdy), 32'd2);
    check("b2b_freeze", 32'(n_frz), 32'd10);
    drop_req();
    clear_stats();
    run_access(1'b1, 1'b0, 32'h0000_040C, 32'h0);
    check("b2b_ld_oe_cnt", 32'(n_oe), BYP ? 32'd0 : 32'd4);
    drop_req();

    // Last-store bypass: only the most recent store is served locally
    run_access(1'b0, 1'b1, 32'h0000_0014, 32'h5A5A_A5A5);
    drop_req();
    run_access(1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_0001);
    drop_req();
    clear_stats();
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    check("byp_hit_freeze", 32'(n_frz), BYP ? 32'd1 : 32'd5);
    check("byp_hit_oe_cnt", 32'(n_oe),  BYP ? 32'd0 : 32'd4);
    check("byp_hit_cycles", 32'(n_cyc), BYP ? 32'd2 : 32'd6);
    drop_req();
    clear_stats();
    run_access(1'b1, 1'b0, 32'h0000_0014, 32'h0);
    check("byp_miss_freeze", 32'(n_frz), 32'd5);
    check("byp_miss_oe_cnt", 32'(n_oe),  32'd4);
    drop_req();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Multi-cycle controller between the MEM stage and a 16-bit asynchronous external SRAM.
- Sequences each 32-bit load/store (mem_read/mem_write from the control path) as two halfword accesses with programmable wait states.
- Drives freeze_out to stall the whole pipeline until the access completes.

Parameters:
- ADDR_W, 18, SRAM halfword address width.
- WAIT_CYCLES, 2, cycles per halfword phase; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_read_in  in  1  load request from MEM stage.
- mem_write_in  in  1  store request from MEM stage.
- addr_in  in  32  byte address; word index = addr_in[ADDR_W:2].
- wdata_in  in  32  store data.
- rdata_out  out  32  load data, valid while ready_out=1.
- ready_out  out  1  one-cycle completion pulse.
- freeze_out  out  1  pipeline stall.
- sram_addr_out  out  ADDR_W  halfword address = {addr_in[ADDR_W:2], half}.
- sram_wdata_out  out  16  write halfword.
- sram_rdata_in  in  16  read halfword.
- sram_we_n_out  out  1  active-low write enable.
- sram_oe_n_out  out  1  active-low output enable.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE; phase counter 0; rdata_out 0; ready_out 0.
  - sram_we_n_out=1, sram_oe_n_out=1, sram_addr_out 0, sram_wdata_out 0.
  - Reset mid-access aborts immediately; no ready pulse follows.
- States: IDLE -> LOW -> HIGH -> DONE -> IDLE.
  - IDLE: if mem_write_in or mem_read_in is set, latch op, address and wdata, then go to LOW.
  - LOW: half=0 for WAIT_CYCLES cycles, then go to HIGH.
  - HIGH: half=1 for WAIT_CYCLES cycles, then go to DONE.
  - DONE: exactly 1 cycle, then unconditionally return to IDLE. The request is still high from the same instruction in DONE and must not restart an access.
- Latched operands: address, wdata and op are latched at IDLE exit. Input changes during LOW/HIGH are ignored.
- Write phase:
  - sram_wdata_out = wdata[15:0] in LOW, wdata[31:16] in HIGH.
  - we_n is low for the first WAIT_CYCLES-1 cycles of each phase and high on the last cycle, so address and data are held past the we_n rising edge.
  - With WAIT_CYCLES=1, we_n is low for the whole phase.
- Read phase:
  - oe_n is low throughout LOW and HIGH.
  - sram_rdata_in is sampled on the last cycle of each phase into the low and high halves of a 32-bit register.
- freeze_out is combinational: (mem_read_in | mem_write_in) & (state != DONE).
  - Frozen cycles per access = 1 + 2*WAIT_CYCLES; with the default that is 5.
  - freeze_out deasserts in the DONE cycle, which is also the ready_out cycle.
- rdata_out:
  - Holds the assembled word from DONE until the next load completes.
  - Stores leave rdata_out unchanged.
- Simultaneous mem_read_in and mem_write_in: write wins.
- Request dropped mid-access: the access still completes and ready_out still pulses. freeze_out follows its equation and therefore drops.
- Back-to-back accesses: a new request seen in the IDLE cycle after DONE starts immediately.

Optional Feature:
- Macro: SRAM_ACCESS_BYPASS_EN.
- With the macro defined:
  - A last-store register {valid, word index, data} is updated on every completed store and cleared by reset.
  - A load in IDLE whose word index matches a valid entry goes straight to DONE; rdata_out = stored data. freeze_out is high for 1 cycle only.
  - No SRAM cycle occurs: we_n and oe_n stay high.
- Without the macro: every load performs the full SRAM sequence.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, LOW=2'd1, HIGH=2'd2, DONE=2'd3);
  - default WAIT_CYCLES and ADDR_W constants;
  - the op-select constant (OP_READ/OP_WRITE).
- One sub-module, sram_phase_timer: a loadable down-counter producing phase_last and we_window.
- FSM, operand latches and the bypass register stay in the top.

Test Plan:
- Store addr=0x0000_0408, wdata=0xDEAD_BEEF, WAIT_CYCLES=2 -> sram_addr 0x204 then 0x205, data 0xBEEF then 0xDEAD. we_n low for 1 cycle per phase. freeze high 5 cycles, ready pulse on cycle 6.
- Load of the same address with SRAM model returning the written halves -> rdata_out=0xDEAD_BEEF with ready_out; oe_n low for 4 cycles; we_n stays high.
- mem_read_in and mem_write_in both high, wdata=0x1234_5678 -> write sequence only; subsequent load returns 0x1234_5678.
- rst_n pulsed low during HIGH of a store -> outputs go to reset values asynchronously, no ready_out; the next request starts cleanly from IDLE.
- Back-to-back load then store with requests held continuously -> second access starts in the IDLE cycle after DONE; total 12 cycles, exactly two ready pulses.
- With SRAM_ACCESS_BYPASS_EN: store 0xCAFE_0001 to 0x10, then load 0x10 -> freeze 1 cycle, rdata 0xCAFE_0001, no oe_n activity. Load 0x14 -> full 5-cycle SRAM read.
